vgaram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the CPU and the text-mode VGA controller.
- The VGA controller has absolute priority. It announces each bus cycle one clock ahead with its access signal, then drives chip-select and address.
- The CPU gets a request/acknowledge port that stalls while the VGA owns the bus.
- The block sits between the CPU bus decoder, the VGA controller's memory port and the RAM macro.

---
 rtl/vgaram_arbiter.sv | 98 +++++++++
 tb/tb_vgaram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vgaram_arbiter.sv
// vgaram_arbiter: shares one single-port video RAM between the VGA controller (absolute priority) and the CPU.
// Define VGARB_POSTED_WRITE_EN for a one-entry posted CPU write buffer.
module vgaram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_vga_addr,
    input  logic              i_vga_cs,
    input  logic              i_vga_access,
    output logic [DATA_W-1:0] o_vga_dat,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_dat,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_we,
    output logic [DATA_W-1:0] o_cpu_dat,
    output logic              o_cpu_ack,
    output logic              o_cpu_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_dat,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    input  logic [DATA_W-1:0] i_ram_dat
);
    typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dat, r_cpu_dat;
    logic              r_we;
    logic              w_capture, w_cpu_issue, w_unused_access;

    // The look-ahead is informational only: the RAM read port pipelines, so it never gates the CPU.
    assign w_unused_access = i_vga_access;

`ifdef VGARB_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
    logic r_wb_valid;

    // Captures wait for an empty buffer so a following read cannot overtake the posted write.
    assign w_capture   = (r_state == IDLE) && i_cpu_cs && !r_wb_valid;
    assign w_cpu_issue = !i_vga_cs && ((r_state == REQ) || r_wb_valid);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_wb_valid <= 1'b0;
        else if (w_capture && i_cpu_we)
            r_wb_valid <= 1'b1;
        else if (!i_vga_cs)
            r_wb_valid <= 1'b0;
    end
`else
    localparam bit POSTED = 1'b0;

    assign w_capture   = (r_state == IDLE) && i_cpu_cs;
    assign w_cpu_issue = (r_state == REQ) && !i_vga_cs;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_next = (POSTED && i_cpu_we) ? DONE : REQ;
            REQ:     if (!i_vga_cs) w_next = r_we ? DONE : RDATA;
            RDATA:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_cpu_dat <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr <= i_cpu_addr;
                r_dat  <= i_cpu_dat;
                r_we   <= i_cpu_we;
            end
            if (r_state == RDATA)
                r_cpu_dat <= i_ram_dat;
        end
    end

    assign o_ram_cs   = i_vga_cs | w_cpu_issue;
    assign o_ram_addr = i_vga_cs ? i_vga_addr : r_addr;
    assign o_ram_we   = w_cpu_issue & r_we;
    assign o_ram_dat  = r_dat;
    assign o_vga_dat  = i_ram_dat;
    assign o_cpu_dat  = r_cpu_dat;
    assign o_cpu_ack  = (r_state == DONE);
    assign o_cpu_busy = (r_state != IDLE);
endmodule

// File: tb/tb_vgaram_arbiter.sv
// tb_vgaram_arbiter: scoreboard bench for vgaram_arbiter with a behavioural synchronous RAM.
// Define VGARB_POSTED_WRITE_EN to exercise the posted-write build.
module tb_vgaram_arbiter;
`ifdef VGARB_POSTED_WRITE_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = 2;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] vga_addr = '0, cpu_addr = '0;
    logic        vga_cs = 1'b0, vga_access = 1'b0;
    logic [7:0]  cpu_dat = '0;
    logic        cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [7:0]  o_vga_dat, o_cpu_dat, o_ram_dat, ram_q;
    logic        o_cpu_ack, o_cpu_busy, o_ram_cs, o_ram_we;
    logic [15:0] o_ram_addr;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [23:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          n_checks = 0, n_errors = 0, rd_issues = 0;
    logic [15:0] last_cpu_addr = '0, prev_vga_addr = '0, vga_next = 16'h8000;
    logic        prev_vga_cs = 1'b0;
    int          vga_burst = 0, ph = 0, lat = 0, lat2 = 0;
    bit          vga_periodic = 1'b0;

    vgaram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_vga_addr(vga_addr), .i_vga_cs(vga_cs), .i_vga_access(vga_access), .o_vga_dat(o_vga_dat),
        .i_cpu_addr(cpu_addr), .i_cpu_dat(cpu_dat), .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we),
        .o_cpu_dat(o_cpu_dat), .o_cpu_ack(o_cpu_ack), .o_cpu_busy(o_cpu_busy),
        .o_ram_addr(o_ram_addr), .o_ram_dat(o_ram_dat), .o_ram_cs(o_ram_cs), .o_ram_we(o_ram_we),
        .i_ram_dat(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_cs) begin
            if (o_ram_we) mem[o_ram_addr] <= o_ram_dat;
            else          ram_q <= mem[o_ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle bus monitor: VGA ownership, VGA data integrity, and the expected-write scoreboard.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n) begin
            if (vga_cs) begin
                check("vga_addr", o_ram_addr, vga_addr);
                check("vga_no_we", o_ram_we, 0);
                check("vga_cs", o_ram_cs, 1);
            end
            if (prev_vga_cs) check("vga_dat", o_vga_dat, ref_mem[prev_vga_addr]);
            if (o_ram_cs && !vga_cs) begin
                last_cpu_addr = o_ram_addr;
                if (!o_ram_we) rd_issues++;
            end
            if (o_ram_we) begin
                check("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check("wr_addr", o_ram_addr, e[23:8]);
                    check("wr_dat", o_ram_dat, e[7:0]);
                end
            end
        end
        prev_vga_cs   = vga_cs;
        prev_vga_addr = vga_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (vga_periodic) begin
            ph = (ph + 1) % 8;
            vga_cs     = (ph == 1 || ph == 2);
            vga_access = (ph == 0 || ph == 1);
        end else if (vga_burst > 0) begin
            vga_cs = 1'b1;
            vga_burst--;
            vga_access = (vga_burst > 0);
        end else begin
            vga_cs     = 1'b0;
            vga_access = 1'b0;
        end
        if (vga_cs) begin
            vga_addr = vga_next;
            vga_next++;
        end
    endtask

    task automatic cpu_txn(input logic [15:0] a, input logic [7:0] d, input logic we,
                           input int vburst, output int n);
        logic [7:0] e;
        int r0;
        e  = '0;
        r0 = rd_issues;
        if (we) begin
            wr_q.push_back({a, d});
            ref_mem[a] = d;
        end else
            rd_q.push_back(ref_mem[a]);
        cpu_cs = 1'b1; cpu_addr = a; cpu_dat = d; cpu_we = we;
        if (vburst > 0) vga_burst = vburst;
        n = 0;
        do begin
            step();
            n++;
            if (o_cpu_busy) begin
                cpu_addr = 16'($urandom);
                cpu_dat  = 8'($urandom);
                cpu_we   = ~we;
            end
        end while (!o_cpu_ack && n < 20);
        check("ack", o_cpu_ack, 1);
        cpu_cs = 1'b0;
        if (!we) begin
            e = rd_q.pop_front();
            check("rd_dat", o_cpu_dat, e);
        end
        step();
        check("ack_one_cycle", o_cpu_ack, 0);
        if (!we) begin
            check("rd_hold", o_cpu_dat, e);
            check("rd_issue_once", rd_issues - r0, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i[7:0] ^ i[15:8]);
            ref_mem[i] = 8'(i[7:0] ^ i[15:8]);
        end
        #1;
        check("rst_ack", o_cpu_ack, 0);
        check("rst_busy", o_cpu_busy, 0);
        check("rst_cpu_dat", o_cpu_dat, 0);
        check("rst_ram_cs", o_ram_cs, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        cpu_txn(16'h1234, 8'hA5, 1'b1, 0, lat);
        check("t1_wr_lat", lat, WR_LAT);
        check("t1_wr_addr", last_cpu_addr, 16'h1234);
        check("t1_drained", wr_q.size(), 0);

        cpu_txn(16'h1234, 8'h00, 1'b0, 0, lat);
        check("t2_rd_lat", lat, 3);

        cpu_txn(16'h0042, 8'h00, 1'b0, 2, lat);
        check("t3_rd_lat", lat, 5);
        check("t3_cpu_addr", last_cpu_addr, 16'h0042);

        for (int i = 0; i < 6; i++)
            cpu_txn(16'h0100 + 16'(i), 8'h10 + 8'(i * 7), 1'b1, 0, lat);
        vga_periodic = 1'b1;
        ph = 0;
        for (int i = 0; i < 16; i++) begin
            cpu_txn(16'h0100 + 16'(i % 6), 8'h00, 1'b0, 0, lat);
            check("t4_lat_le5", lat <= 5, 1);
        end
        vga_periodic = 1'b0;
        repeat (3) step();

        wr_q.push_back({16'h2222, 8'h5A});
        cpu_cs = 1'b1; cpu_addr = 16'h2222; cpu_dat = 8'h5A; cpu_we = 1'b1;
        vga_burst = 4;
        step();
`ifdef VGARB_POSTED_WRITE_EN
        check("t5_posted_ack", o_cpu_ack, 1);
        cpu_cs = 1'b0;
        step();
`else
        step();
        check("t5_in_req", o_cpu_busy, 1);
        check("t5_no_ack", o_cpu_ack, 0);
`endif
        rst_n  = 1'b0;
        cpu_cs = 1'b0;
        #1;
        check("t5_ack", o_cpu_ack, 0);
        check("t5_idle", o_cpu_busy, 0);
        check("t5_cpu_dat", o_cpu_dat, 0);
        check("t5_ram_we", o_ram_we, 0);
        step(); step();
        wr_q.delete();
        rst_n = 1'b1;
        repeat (6) step();
        check("t5_mem_kept", mem[16'h2222], ref_mem[16'h2222]);
        check("t5_still_idle", o_cpu_busy, 0);

`ifdef VGARB_POSTED_WRITE_EN
        cpu_txn(16'h3333, 8'hC3, 1'b1, 3, lat);
        check("t6_wr_lat", lat, 1);
        cpu_txn(16'h3333, 8'h00, 1'b0, 0, lat2);
        check("t6_rd_after_drain", lat2 > 3, 1);
        check("t6_drained", wr_q.size(), 0);
`endif
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
